dma_fifo_exmem: RTL and testbench
=================================

Name: dma_fifo_exmem

Overview:
- Synchronous single-clock FIFO controller whose storage lives in an external dual-port RAM reached through a flat memory port group.
- Shows the head entry (first-word-fall-through) and reports full, empty and free space.
- Used, with different widths, for the AXI slave write-address, write-data and write-response queues; those three instances are dma_fifo_exmem_swchaddr, dma_fifo_exmem_swchdata and dma_fifo_exmem_swchrsp, which are thin wrappers around this block.

Parameters:
- DWIDTH, 32, entry width in bits (36 for address queue, 32 for data queue, 6 for response queue).
- AWIDTH, 5, pointer/address width; depth = 2**AWIDTH entries (32 by default).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- push  in  1  write request; data_in is stored when accepted.
- pull  in  1  pop request; removes the head entry when accepted.
- data_in  in  DWIDTH  entry to store.
- data_out  out  DWIDTH  head entry; equals mem_rd_data, valid while empty=0.
- depth_left  out  AWIDTH+1  number of free entries, range 0..2**AWIDTH.
- full  out  1  high when the FIFO holds 2**AWIDTH entries.
- empty  out  1  high when the FIFO holds 0 entries.
- mem_wr_en  out  1  external RAM write strobe.
- mem_wr_addr  out  AWIDTH  external RAM write address (write pointer).
- mem_wr_data  out  DWIDTH  external RAM write data; equals data_in.
- mem_rd_addr  out  AWIDTH  external RAM read address (read pointer).
- mem_rd_data  in  DWIDTH  external RAM read data; combinational (asynchronous) read of mem_rd_addr.

Behaviour:
- State: write pointer wp and read pointer rp, each AWIDTH+1 bits.
  - The low AWIDTH bits address the RAM; the MSB is the wrap bit.
  - Count = wp - rp, computed modulo 2**(AWIDTH+1).
- Reset (rst=1, asynchronous):
  - wp=0, rp=0, so empty=1, full=0, depth_left=2**AWIDTH.
  - mem_wr_en=0 while reset is asserted.
  - A reset asserted mid-operation discards all contents immediately. RAM contents are not cleared.
- Flags, all combinational from the pointers:
  - empty = (wp==rp).
  - full = (low bits equal and MSBs differ).
  - depth_left = 2**AWIDTH - count.
- Push acceptance: accept = push & !full.
  - mem_wr_en = accept, combinational in the same cycle.
  - The RAM captures data_in at wp[AWIDTH-1:0] on that edge; wp increments by 1 with natural wrap.
- Pull acceptance: accept = pull & !empty.
  - rp increments on the edge.
  - data_out is the head before the edge and the next entry after it.
- Latency: an entry pushed into an empty FIFO appears on data_out and empty falls in the cycle after the push edge. This is zero extra latency (fall-through).
- Simultaneous push and pull:
  - Both are accepted when the FIFO is neither full nor empty; count and depth_left are unchanged.
  - When empty, only the push is accepted.
  - When full, only the pull is accepted; the push is dropped and the caller must hold it.
- Illegal requests:
  - Push while full is ignored: no RAM write, pointers unchanged.
  - Pull while empty is ignored.
  - Neither corrupts state.
- Wrap-around: after 2**AWIDTH pushes and pulls, the pointers wrap with correct ordering and flags.
- data_out while empty=1 is don't-care; consumers must gate on empty.
- No other registered outputs. All outputs settle within the cycle from pointers, push, pull and mem_rd_data.

Optional Feature:
- Macro DMA_FIFO_ERR_EN.
- When defined, two extra outputs exist:
  - overflow (1 bit): set on the edge where push=1 & full=1.
  - underflow (1 bit): set on the edge where pull=1 & empty=1.
  - Both are sticky and are cleared only by rst (to 0).
- When not defined, these ports and their logic are absent and the interface is exactly as listed above.

Test Plan:
- Reset then idle: assert rst mid-cycle -> empty=1, full=0, depth_left=32, mem_wr_en=0 immediately, before any clock edge.
- Single entry (DWIDTH=36): push 36'h8_0000_1000 once -> next cycle empty=0, depth_left=31, data_out=36'h8_0000_1000; pull once -> empty=1, depth_left=32.
- Fill (AWIDTH=5): push 0..31 -> full=1, depth_left=0 after 32nd push; 33rd push leaves mem_wr_en=0, pointers unchanged, and with DMA_FIFO_ERR_EN overflow=1; then pull 32 times -> data_out sequence 0..31, empty=1.
- Concurrent: with 3 entries, push and pull together for 10 cycles -> depth_left stays 29, output order preserved.
- Wrap: 100 push-then-pull pairs of incrementing data -> every popped value equals the pushed value, mem_wr_addr cycles 0..31; pull on empty leaves empty=1 and sets underflow when DMA_FIFO_ERR_EN is defined.

Source files
------------

// File: rtl/dma_fifo_exmem.sv
// FIFO controller whose storage is an external dual-port RAM; head entry shown fall-through.
// Latency: a push into an empty FIFO is visible on data_out the cycle after the push edge.
// Backpressure: push ignored while full, pull ignored while empty; caller holds requests.
// Optional sticky overflow/underflow outputs exist when DMA_FIFO_ERR_EN is defined.
module dma_fifo_exmem #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pull,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic [AWIDTH:0]   depth_left,
  output logic              full,
  output logic              empty,
  output logic              mem_wr_en,
  output logic [AWIDTH-1:0] mem_wr_addr,
  output logic [DWIDTH-1:0] mem_wr_data,
  output logic [AWIDTH-1:0] mem_rd_addr,
  input  logic [DWIDTH-1:0] mem_rd_data
`ifdef DMA_FIFO_ERR_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AWIDTH:0] wp;
  logic [AWIDTH:0] rp;
  logic [AWIDTH:0] count;
  logic [AWIDTH:0] depth_total;
  logic            push_ok;
  logic            pull_ok;

  assign depth_total = {1'b1, {AWIDTH{1'b0}}};
  assign count       = wp - rp;

  assign empty      = (wp == rp);
  assign full       = (wp[AWIDTH-1:0] == rp[AWIDTH-1:0]) && (wp[AWIDTH] != rp[AWIDTH]);
  assign depth_left = depth_total - count;

  // The write strobe is held off during reset so the RAM is never touched then.
  assign push_ok = push && !full && !rst;
  assign pull_ok = pull && !empty;

  assign mem_wr_en   = push_ok;
  assign mem_wr_addr = wp[AWIDTH-1:0];
  assign mem_wr_data = data_in;
  assign mem_rd_addr = rp[AWIDTH-1:0];
  assign data_out    = mem_rd_data;

  // Advance the write pointer on each accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
    end else if (push_ok) begin
      wp <= wp + 1'b1;
    end
  end

  // Advance the read pointer on each accepted pull.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp <= '0;
    end else if (pull_ok) begin
      rp <= rp + 1'b1;
    end
  end

`ifdef DMA_FIFO_ERR_EN
  // Sticky error flags: record any request that was refused; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full) begin
        overflow <= 1'b1;
      end
      if (pull && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dma_fifo_exmem.sv
// Directed bench for dma_fifo_exmem with an external RAM model and a scoreboard queue.
// Each step drives requests just after a rising edge and checks outputs before the next one.
// Expected data comes from the queue filled at push time; flags come from a count model.
module tb_dma_fifo_exmem;

  localparam int DW = 36;
  localparam int AW = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic          pull;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic [AW:0]   depth_left;
  logic          full;
  logic          empty;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
`ifdef DMA_FIFO_ERR_EN
  logic          overflow;
  logic          underflow;
`endif

  dma_fifo_exmem #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pull        (pull),
    .data_in     (data_in),
    .data_out    (data_out),
    .depth_left  (depth_left),
    .full        (full),
    .empty       (empty),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data)
`ifdef DMA_FIFO_ERR_EN
    ,
    .overflow    (overflow),
    .underflow   (underflow)
`endif
  );

  always #5 clk = ~clk;

  // External dual-port RAM: synchronous write, asynchronous read.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
  end
  assign mem_rd_data = ram[mem_rd_addr];

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] sb[$];
  int            cnt_m;
  int            wp_m;
  bit            ovf_m;
  bit            unf_m;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, ".empty"}, 64'(empty), 64'(cnt_m == 0));
    chk({tag, ".full"}, 64'(full), 64'(cnt_m == DEPTH));
    chk({tag, ".depth_left"}, 64'(depth_left), 64'(DEPTH - cnt_m));
    if (cnt_m > 0) chk({tag, ".head"}, 64'(data_out), 64'(sb[0]));
`ifdef DMA_FIFO_ERR_EN
    chk({tag, ".overflow"}, 64'(overflow), 64'(ovf_m));
    chk({tag, ".underflow"}, 64'(underflow), 64'(unf_m));
`endif
  endtask

  // One clock step: drive requests, check the same-cycle outputs, take the edge, check flags.
  task automatic cycle(input bit p, input bit q, input logic [DW-1:0] d, input string tag);
    bit acc_p;
    bit acc_q;
    logic [DW-1:0] exp;
    push = p; pull = q; data_in = d;
    #1;
    acc_p = p && (cnt_m < DEPTH);
    acc_q = q && (cnt_m > 0);
    if (p) chk({tag, ".wr_en"}, 64'(mem_wr_en), 64'(acc_p));
    if (acc_p) begin
      chk({tag, ".wr_addr"}, 64'(mem_wr_addr), 64'(wp_m % DEPTH));
      chk({tag, ".wr_data"}, 64'(mem_wr_data), 64'(d));
    end
    if (acc_q) begin
      exp = sb.pop_front();
      chk({tag, ".pop"}, 64'(data_out), 64'(exp));
    end
    if (acc_p) begin
      sb.push_back(d);
      wp_m++;
    end
    if (p && !acc_p) ovf_m = 1'b1;
    if (q && cnt_m == 0) unf_m = 1'b1;
    cnt_m = cnt_m + int'(acc_p) - int'(acc_q);
    @(posedge clk);
    #1;
    push = 1'b0; pull = 1'b0;
    #1;
    chk_flags(tag);
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pull = 1'b0; data_in = '0;
    cnt_m = 0; wp_m = 0; ovf_m = 1'b0; unf_m = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk_flags("reset");

    // Load two entries, then assert reset mid-cycle with a push pending.
    cycle(1, 0, 36'h1_1111_1111, "pre_rst0");
    cycle(1, 0, 36'h2_2222_2222, "pre_rst1");
    push = 1'b1; data_in = 36'h3_3333_3333;
    #2 rst = 1'b1;
    #1;
    sb.delete(); cnt_m = 0; wp_m = 0; ovf_m = 1'b0; unf_m = 1'b0;
    chk("midrst.wr_en", 64'(mem_wr_en), 64'd0);
    chk_flags("midrst");
    @(posedge clk);
    #1 push = 1'b0; rst = 1'b0;
    #1 chk_flags("post_rst");

    // Single entry fall-through and removal.
    cycle(1, 0, 36'h8_0000_1000, "single_push");
    cycle(0, 1, '0, "single_pull");

    // Push and pull together while empty: only the push is taken.
    cycle(1, 1, 36'h0_0000_0aaa, "pp_empty");
    cycle(0, 1, '0, "pp_empty_drain");

    // Fill, refused push, push+pull on full, then drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, DW'(i), "fill");
    cycle(1, 0, 36'h0_0000_0099, "over_push");
    cycle(1, 1, 36'h0_0000_0077, "pp_full");
    cycle(1, 0, 36'h0_0000_0055, "refill");
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, '0, "drain");

    // Concurrent traffic with three entries resident.
    for (int i = 0; i < 3; i++) cycle(1, 0, DW'(36'h5_0000_0000 + i), "conc_pre");
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, DW'(36'h6_0000_0000 + i), "conc");
      chk("conc.depth29", 64'(depth_left), 64'd29);
    end
    for (int i = 0; i < 3; i++) cycle(0, 1, '0, "conc_drain");

    // Pointer wrap over many push-then-pull pairs.
    for (int i = 0; i < 100; i++) begin
      cycle(1, 0, DW'(36'h7_0000_0000 + i), "wrap_push");
      cycle(0, 1, '0, "wrap_pull");
    end

    // Pull on empty is ignored (and latches underflow where present).
    cycle(0, 1, '0, "under_pull");
    chk("under.empty", 64'(empty), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
